intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt controller between the 8 external interrupt lines and the pipeline.
- Detects rising edges on `intr`, holds them as pending, and applies a mask and a global enable.
- Selects one cause by fixed priority and runs a request/acknowledge handshake with the pipeline.
- On acknowledge it captures the faulting PC (`mem_pc`) as EPC; it then blocks further requests until the pipeline signals return-from-exception (`eret`). No nesting.

Parameters:
- NUM_IRQ, 8, number of interrupt lines (cause width = clog2(NUM_IRQ)).
- PC_W, 32, width of `mem_pc` and `epc`.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- intr  in  NUM_IRQ  interrupt lines; synchronous to clk; rising edge = event
- cfg_we  in  1  write strobe for mask/enable register
- cfg_wdata  in  NUM_IRQ+1  [NUM_IRQ-1:0] = mask (1 = enabled), [NUM_IRQ] = global enable ie
- irq_ack  in  1  pipeline accepts the current request (from the MEM stage)
- mem_pc  in  PC_W  PC of the instruction in MEM; sampled on accepted ack
- eret  in  1  handler return; leaves service
- irq_req  out  1  interrupt request to pipeline
- irq_cause  out  clog2(NUM_IRQ)  index of the requested line
- epc  out  PC_W  captured exception PC
- pending  out  NUM_IRQ  pending bits
- mask  out  NUM_IRQ+1  current {ie, mask}
- in_service  out  1  high while in state SERVICE

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, pending=0, mask=0 (ie=0), intr_d=0, epc=0, irq_cause=0, irq_req=0, in_service=0. Reset mid-handshake drops `irq_req` at the next edge with no EPC update.
- Edge detect: `intr_d` is a register of `intr`; rise = intr & ~intr_d. At each posedge, pending <= (pending & ~clr) | rise.
  - `clr` is one-hot of `irq_cause` when an ack is accepted, else 0.
  - Simultaneous rise and clear on the same bit: set wins; the bit stays pending.
- Eligible: elig = pending & mask[NUM_IRQ-1:0], gated by ie. Priority: lowest index wins.
- FSM states: IDLE, REQ, SERVICE. `irq_req` = (state==REQ); `in_service` = (state==SERVICE); both are registered state decodes.
  - IDLE: if elig != 0, go to REQ and latch irq_cause = priority index.
  - REQ, irq_ack=1: go to SERVICE; epc <= mem_pc; clear pending[irq_cause].
  - REQ, irq_ack=0 and elig[irq_cause]=0 (masked, or ie cleared by cfg write): go to IDLE (withdraw).
  - REQ, otherwise: stay. `irq_cause` is frozen in REQ; a higher-priority arrival does not preempt it.
  - SERVICE, eret=1: go to IDLE. Otherwise stay; new edges still accumulate in `pending`.
- Latency: `intr` rises in cycle N → pending visible N+1 → irq_req=1 in cycle N+2 (if enabled and IDLE). After eret in cycle M, IDLE in M+1; a still-eligible pending causes irq_req=1 in M+2.
- cfg write: mask <= cfg_wdata at posedge, effective for the elig evaluation in the next cycle. cfg_we and ack in the same cycle in REQ: ack wins (ack is evaluated against the pre-write elig).
- Ignored inputs: irq_ack outside REQ; eret outside SERVICE.
- Masked lines: still set `pending`; they become requestable when unmasked.

Decomposition:
- Shared package (cp0_pkg):
  - state encoding IDLE=2'd0, REQ=2'd1, SERVICE=2'd2
  - NUM_IRQ default
  - cfg_wdata field positions (IE_BIT=NUM_IRQ)
- Sub-module `prio_enc`: parameterised lowest-index-first priority encoder (input vector → index + valid). Used for cause selection.

Test Plan:
1. Reset, write cfg {ie=1, mask=8'hFF}; pulse intr[3] at cycle 10 → pending[3] at 11, irq_req=1 with cause=3 at 12. Ack with mem_pc=32'h0040_0020 → epc=32'h0040_0020, in_service=1, pending=0.
2. With mask=8'hFF and ie=1, raise intr[5] and intr[2] in the same cycle → cause=2. Ack, then eret → IDLE, then a request with cause=5 two cycles after eret. Ack with mem_pc=32'h0040_0100 → epc updates.
3. mask=8'h00, ie=1; pulse intr[1] → pending[1]=1, irq_req stays 0. Write mask=8'h02 → irq_req=1, cause=1, two cycles after the write.
4. In REQ (cause=4), write ie=0 without ack → irq_req drops next cycle, pending[4] stays 1. Rewrite ie=1 → request for cause 4 resumes.
5. While in SERVICE, pulse intr[0]; irq_ack and eret pulses are issued out of state → no epc change, no extra state change. After eret, cause=0 is requested.
6. In REQ, assert rst for one cycle → irq_req=0, pending=0, epc=0, mask=0 after that edge. A new intr[0] edge is ignored until ie is written.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default
// sizes and the position of the global-enable bit in the config word.
package cp0_pkg;

  localparam int NUM_IRQ_DEF = 8;
  localparam int PC_W_DEF    = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  // The global enable sits just above the per-line mask bits.
  function automatic int ie_bit(input int num_irq);
    return num_irq;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder: returns the index of the lowest set
// bit of vec, with valid flagging that any bit was set.
module prio_enc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detects the interrupt lines into pending bits,
// masks them, and runs a single non-nesting request/ack/eret handshake.
module intr_ctrl
  import cp0_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int PC_W    = PC_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IRQ-1:0]         intr,
  input  logic                       cfg_we,
  input  logic [NUM_IRQ:0]           cfg_wdata,
  input  logic                       irq_ack,
  input  logic [PC_W-1:0]            mem_pc,
  input  logic                       eret,
  output logic                       irq_req,
  output logic [$clog2(NUM_IRQ)-1:0] irq_cause,
  output logic [PC_W-1:0]            epc,
  output logic [NUM_IRQ-1:0]         pending,
  output logic [NUM_IRQ:0]           mask,
  output logic                       in_service
);

  localparam int CW     = $clog2(NUM_IRQ);
  localparam int IE_BIT = ie_bit(NUM_IRQ);

  logic [1:0]         state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ:0]   mask_q, mask_d;
  logic [NUM_IRQ-1:0] intr_d_q;
  logic [PC_W-1:0]    epc_q, epc_d;
  logic [CW-1:0]      cause_q, cause_d;

  logic [NUM_IRQ-1:0] rise, clr, elig;
  logic [CW-1:0]      prio_idx;
  logic               prio_valid;
  logic               ack_acc;

  prio_enc #(.N(NUM_IRQ), .W(CW)) u_prio (
    .vec   (elig),
    .idx   (prio_idx),
    .valid (prio_valid)
  );

  assign rise    = intr & ~intr_d_q;
  assign elig    = mask_q[IE_BIT] ? (pending_q & mask_q[NUM_IRQ-1:0]) : '0;
  assign ack_acc = (state_q == ST_REQ) && irq_ack;

  always_comb begin
    clr = '0;
    if (ack_acc) clr[cause_q] = 1'b1;
    // A fresh edge on the bit being acknowledged keeps it pending.
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = cfg_we ? cfg_wdata : mask_q;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    case (state_q)
      ST_IDLE: begin
        if (prio_valid) begin
          state_d = ST_REQ;
          cause_d = prio_idx;
        end
      end
      ST_REQ: begin
        // Ack is judged against the mask as it stood before any same-cycle write.
        if (irq_ack) begin
          state_d = ST_SERVICE;
          epc_d   = mem_pc;
        end else if (!elig[cause_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      intr_d_q  <= '0;
      epc_q     <= '0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      intr_d_q  <= intr;
      epc_q     <= epc_d;
      cause_q   <= cause_d;
    end
  end

  assign irq_req    = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign irq_cause  = cause_q;
  assign epc        = epc_q;
  assign pending    = pending_q;
  assign mask       = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: expected requests ({cycle, cause}) are queued
// by the stimulus and checked by a monitor on each new irq_req assertion.
module tb_intr_ctrl;

  localparam int W = 19;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  intr;
  logic        cfg_we;
  logic [8:0]  cfg_wdata;
  logic        irq_ack;
  logic [31:0] mem_pc;
  logic        eret;
  logic        irq_req;
  logic [2:0]  irq_cause;
  logic [31:0] epc;
  logic [7:0]  pending;
  logic [8:0]  mask;
  logic        in_service;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic prev_req = 1'b0;
  logic [W-1:0] exp_q[$];

  intr_ctrl #(.NUM_IRQ(8), .PC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .intr       (intr),
    .cfg_we     (cfg_we),
    .cfg_wdata  (cfg_wdata),
    .irq_ack    (irq_ack),
    .mem_pc     (mem_pc),
    .eret       (eret),
    .irq_req    (irq_req),
    .irq_cause  (irq_cause),
    .epc        (epc),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every new request must match the head of the expected queue.
  always @(negedge clk) begin
    if (irq_req && !prev_req) begin
      logic [W-1:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: got cause=%0d at cycle %0d, expected no request", irq_cause, cyc);
      end else begin
        e = exp_q.pop_front();
        if (irq_cause !== e[2:0] || cyc[15:0] !== e[W-1:3]) begin
          errors++;
          $display("FAIL req: got cause=%0d cycle=%0d, expected cause=%0d cycle=%0d",
                   irq_cause, cyc, e[2:0], e[W-1:3]);
        end
      end
    end
    prev_req = irq_req;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_req(input logic [2:0] cause, input int lat);
    int c;
    c = cyc + lat;
    exp_q.push_back({c[15:0], cause});
  endtask

  task automatic pulse_intr(input logic [7:0] bits);
    intr = bits;
    tick();
    intr = '0;
  endtask

  task automatic cfg_write(input logic [8:0] v);
    cfg_we = 1'b1;
    cfg_wdata = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] pc);
    irq_ack = 1'b1;
    mem_pc = pc;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!irq_req && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!irq_req) begin
      errors++;
      $display("FAIL %s_timeout: irq_req=0 after 20 cycles, expected 1", name);
    end
  endtask

  initial begin
    rst = 1'b1; intr = '0; cfg_we = 1'b0; cfg_wdata = '0;
    irq_ack = 1'b0; mem_pc = '0; eret = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_req", {31'd0, irq_req}, 32'd0);
    check("rst_svc", {31'd0, in_service}, 32'd0);
    check("rst_pending", {24'd0, pending}, 32'd0);
    check("rst_mask", {23'd0, mask}, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_cause", {29'd0, irq_cause}, 32'd0);

    // 1: single line, basic latency and EPC capture
    cfg_write(9'h1FF);
    while (cyc < 9) tick();
    expect_req(3'd3, 2);
    pulse_intr(8'h08);
    check("t1_pending", {24'd0, pending}, 32'h08);
    check("t1_req_early", {31'd0, irq_req}, 32'd0);
    wait_req("t1");
    check("t1_cause", {29'd0, irq_cause}, 32'd3);
    do_ack(32'h0040_0020);
    check("t1_epc", epc, 32'h0040_0020);
    check("t1_svc", {31'd0, in_service}, 32'd1);
    check("t1_pending_clr", {24'd0, pending}, 32'd0);
    do_eret();
    check("t1_idle", {30'd0, in_service, irq_req}, 32'd0);

    // 2: simultaneous edges, priority, re-request after eret
    expect_req(3'd2, 2);
    pulse_intr(8'h24);
    wait_req("t2a");
    do_ack(32'h0040_0040);
    check("t2_pending", {24'd0, pending}, 32'h20);
    expect_req(3'd5, 2);
    do_eret();
    check("t2_not_yet", {31'd0, irq_req}, 32'd0);
    wait_req("t2b");
    do_ack(32'h0040_0100);
    check("t2_epc", epc, 32'h0040_0100);
    do_eret();

    // 3: masked line pends, then unmask
    cfg_write(9'h100);
    pulse_intr(8'h02);
    tick(); tick();
    check("t3_pending", {24'd0, pending}, 32'h02);
    check("t3_masked", {31'd0, irq_req}, 32'd0);
    expect_req(3'd1, 2);
    cfg_write(9'h102);
    wait_req("t3");
    do_ack(32'h0040_0180);
    do_eret();

    // 4: withdraw on ie clear, resume on ie set
    cfg_write(9'h1FF);
    expect_req(3'd4, 2);
    pulse_intr(8'h10);
    wait_req("t4a");
    cfg_write(9'h0FF);
    check("t4_req_hold", {31'd0, irq_req}, 32'd1);
    tick();
    check("t4_withdrawn", {31'd0, irq_req}, 32'd0);
    check("t4_pending", {24'd0, pending}, 32'h10);
    expect_req(3'd4, 2);
    cfg_write(9'h1FF);
    wait_req("t4b");
    do_ack(32'h0040_0200);
    do_eret();

    // 4b: ack and mask-clearing write in the same cycle, ack wins
    expect_req(3'd6, 2);
    pulse_intr(8'h40);
    wait_req("t4c");
    irq_ack = 1'b1; mem_pc = 32'h0040_0240; cfg_we = 1'b1; cfg_wdata = 9'h000;
    tick();
    irq_ack = 1'b0; cfg_we = 1'b0;
    check("t4c_svc", {31'd0, in_service}, 32'd1);
    check("t4c_epc", epc, 32'h0040_0240);
    check("t4c_mask", {23'd0, mask}, 32'd0);
    cfg_write(9'h1FF);
    do_eret();

    // 5: ignored ack/eret out of state, edges accumulate in service
    expect_req(3'd7, 2);
    pulse_intr(8'h80);
    wait_req("t5a");
    do_ack(32'h0040_0300);
    pulse_intr(8'h01);
    check("t5_pending", {24'd0, pending}, 32'h01);
    do_ack(32'h0040_0400);
    check("t5_epc_keep", epc, 32'h0040_0300);
    check("t5_svc_keep", {31'd0, in_service}, 32'd1);
    expect_req(3'd0, 2);
    do_eret();
    wait_req("t5b");
    do_eret();
    check("t5_req_keep", {30'd0, in_service, irq_req}, 32'd1);
    do_ack(32'h0040_0500);
    check("t5_epc", epc, 32'h0040_0500);
    do_eret();
    do_ack(32'h0040_0600);
    check("t5_idle_ack", {30'd0, in_service, irq_req}, 32'd0);
    check("t5_epc_idle", epc, 32'h0040_0500);
    do_eret();
    check("t5_idle_eret", {30'd0, in_service, irq_req}, 32'd0);

    // 6: reset mid-request
    expect_req(3'd3, 2);
    pulse_intr(8'h08);
    wait_req("t6a");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_req", {31'd0, irq_req}, 32'd0);
    check("t6_pending", {24'd0, pending}, 32'd0);
    check("t6_epc", epc, 32'd0);
    check("t6_mask", {23'd0, mask}, 32'd0);
    check("t6_svc", {31'd0, in_service}, 32'd0);
    pulse_intr(8'h01);
    tick(); tick(); tick();
    check("t6_no_req", {31'd0, irq_req}, 32'd0);
    check("t6_pend0", {24'd0, pending}, 32'h01);
    expect_req(3'd0, 2);
    cfg_write(9'h1FF);
    wait_req("t6b");
    check("t6_cause", {29'd0, irq_cause}, 32'd0);

    tick(); tick();
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
